// File: rtl/lcd_status.sv
// Display-status stage: samples the scanline/hblank, maintains DISPSTAT/VCOUNT,
// and emits one-cycle IRQ and DMA trigger pulses on VBlank/HBlank/VCount-match edges.
module lcd_status #(
  parameter logic [7:0] VBLANK_START = 8'd160,
  parameter logic [7:0] VBLANK_END   = 8'd227,
  parameter logic [7:0] LAST_LINE    = 8'd227
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_v_addr,
  input  logic        i_hblank,
  input  logic        i_dispstat_we,
  input  logic [15:0] i_dispstat_wdata,
  output logic [15:0] o_dispstat,
  output logic [15:0] o_vcount,
  output logic        o_irq_vblank,
  output logic        o_irq_hblank,
  output logic        o_irq_vcount,
  output logic        o_dma_vblank,
  output logic        o_dma_hblank
);

  typedef enum logic [1:0] {
    ARM_IDLE,
    ARM_FILL,
    ARM_LIVE
  } arm_t;

  arm_t       r_arm;
  arm_t       w_arm_next;

  logic [7:0] r_line;
  logic       r_hb;
  logic       r_vbl;
  logic       r_hbl;
  logic       r_match;
  logic [2:0] r_en;
  logic [7:0] r_lyc;

  logic       r_irq_vblank;
  logic       r_irq_hblank;
  logic       r_irq_vcount;
  logic       r_dma_vblank;
  logic       r_dma_hblank;

  logic       w_armed;
  logic       w_vbl_next;
  logic       w_hbl_next;
  logic       w_match_next;
  logic       w_vbl_rise;
  logic       w_hbl_rise;
  logic       w_match_rise;
  logic [7:0] w_line_clamped;

  // Arming waits until the flag registers hold values derived from real samples,
  // so the reset-to-live flag transition never looks like an edge.
  always_comb begin
    w_arm_next = r_arm;
    case (r_arm)
      ARM_IDLE: w_arm_next = ARM_FILL;
      ARM_FILL: w_arm_next = ARM_LIVE;
      default:  w_arm_next = ARM_LIVE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_arm <= ARM_IDLE;
    else       r_arm <= w_arm_next;
  end

  assign w_armed        = (r_arm == ARM_LIVE);
  assign w_line_clamped = (i_v_addr > LAST_LINE) ? LAST_LINE : i_v_addr;

  assign w_vbl_next   = (r_line >= VBLANK_START) && (r_line < VBLANK_END);
  assign w_hbl_next   = r_hb;
  assign w_match_next = (r_line == r_lyc);

  assign w_vbl_rise   = w_armed && w_vbl_next   && !r_vbl;
  assign w_hbl_rise   = w_armed && w_hbl_next   && !r_hbl;
  assign w_match_rise = w_armed && w_match_next && !r_match;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_line       <= '0;
      r_hb         <= 1'b0;
      r_vbl        <= 1'b0;
      r_hbl        <= 1'b0;
      r_match      <= 1'b0;
      r_en         <= '0;
      r_lyc        <= '0;
      r_irq_vblank <= 1'b0;
      r_irq_hblank <= 1'b0;
      r_irq_vcount <= 1'b0;
      r_dma_vblank <= 1'b0;
      r_dma_hblank <= 1'b0;
    end else begin
      r_line  <= w_line_clamped;
      r_hb    <= i_hblank;
      r_vbl   <= w_vbl_next;
      r_hbl   <= w_hbl_next;
      r_match <= w_match_next;
      // Pulses register alongside their flag and use the pre-write enables.
      r_irq_vblank <= w_vbl_rise   && r_en[0];
      r_irq_hblank <= w_hbl_rise   && r_en[1];
      r_irq_vcount <= w_match_rise && r_en[2];
      r_dma_vblank <= w_vbl_rise;
      r_dma_hblank <= w_hbl_rise && (r_line < VBLANK_START);
      if (i_dispstat_we) begin
        r_en  <= i_dispstat_wdata[5:3];
        r_lyc <= i_dispstat_wdata[15:8];
      end
    end
  end

  assign o_dispstat   = {r_lyc, 2'b00, r_en, r_match, r_hbl, r_vbl};
  assign o_vcount     = {8'h00, r_line};
  assign o_irq_vblank = r_irq_vblank;
  assign o_irq_hblank = r_irq_hblank;
  assign o_irq_vcount = r_irq_vcount;
  assign o_dma_vblank = r_dma_vblank;
  assign o_dma_hblank = r_dma_hblank;

endmodule
